// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Inter-stage pipeline register for the five-stage MIPS core (D/E, E/M, M/W).
// It carries an opaque payload, the PC and the hazard bookkeeping
// (Tnew, GRF write enable, GRF write address A3) through DEPTH chained
// register slices. It supports stall (hold), bubble insertion at entry
// (flush) and clearing the whole register (flush_all).
//
// Parameters
//   PAYLOAD_W          width of the opaque payload
//   PC_W               width of the PC field
//   TNEW_W             width of the Tnew field
//   DEPTH              number of chained slices, 1..4
//   KEEP_PC_ON_BUBBLE  1: a flush bubble takes in_pc, 0: it takes PC_RESET
//   PC_RESET           PC of every slice after reset or flush_all
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset
//   hold         in   freeze every slice (stage stalled)
//   flush        in   load a bubble into slice 0, later slices advance
//   flush_all    in   clear every slice to a bubble
//   in_valid     in   upstream instruction is real
//   in_payload   in   upstream payload
//   in_pc        in   upstream PC
//   in_tnew      in   upstream Tnew
//   in_wegrf     in   upstream GRF write enable
//   in_a3        in   upstream GRF write address
//   out_valid    out  last slice holds a real instruction
//   out_payload  out  last slice payload
//   out_pc       out  last slice PC
//   out_tnew     out  last slice Tnew
//   out_wegrf    out  last slice write enable (already gated)
//   out_a3       out  last slice write address (0 whenever out_wegrf is 0)
//   busy         out  OR of valid over all slices
//
// Flow control: there is no valid/ready handshake. The upstream stage
// presents in_* every cycle; the register captures it on every rising edge
// on which hold is low (unless flush replaces it with a bubble). While hold
// is high nothing moves and in_* is ignored, so the upstream stage must keep
// its own instruction stalled in the same cycle. in_valid only tags whether
// the captured slot carries a real instruction.
//
// Edge priority: reset > flush_all > hold > flush > normal advance.
//
// Invariants kept on every slice: wegrf=0 -> a3=0, and valid=0 -> wegrf=0
// and tnew=0. Hazard units can therefore compare a3 without looking at valid.
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int unsigned        PAYLOAD_W         = 128,
  parameter int unsigned        PC_W              = 32,
  parameter int unsigned        TNEW_W            = 2,
  parameter int unsigned        DEPTH             = 1,
  parameter bit                 KEEP_PC_ON_BUBBLE = 1'b1,
  parameter logic [PC_W-1:0]    PC_RESET          = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hold,
  input  logic                 flush,
  input  logic                 flush_all,
  input  logic                 in_valid,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [PC_W-1:0]      in_pc,
  input  logic [TNEW_W-1:0]    in_tnew,
  input  logic                 in_wegrf,
  input  logic [4:0]           in_a3,
  output logic                 out_valid,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [PC_W-1:0]      out_pc,
  output logic [TNEW_W-1:0]    out_tnew,
  output logic                 out_wegrf,
  output logic [4:0]           out_a3,
  output logic                 busy
);

  // -------------------------------------------------------------------------
  // Elaboration-time parameter check
  // -------------------------------------------------------------------------
  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("pipe_stage_reg: DEPTH must be in 1..4");
  end

  // -------------------------------------------------------------------------
  // Slice storage. Index 0 is the entry slice, DEPTH-1 drives the outputs.
  // -------------------------------------------------------------------------
  logic [DEPTH-1:0]                valid_q,   valid_d;
  logic [DEPTH-1:0][PAYLOAD_W-1:0] payload_q, payload_d;
  logic [DEPTH-1:0][PC_W-1:0]      pc_q,      pc_d;
  logic [DEPTH-1:0][TNEW_W-1:0]    tnew_q,    tnew_d;
  logic [DEPTH-1:0]                wegrf_q,   wegrf_d;
  logic [DEPTH-1:0][4:0]           a3_q,      a3_d;

  // Tnew counts the cycles until the result exists; one slice = one cycle.
  function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - TNEW_W'(1);
  endfunction

  // -------------------------------------------------------------------------
  // Entry gating. A write to $0 is dropped here so that it can never show up
  // as a hazard downstream; an invalid slot carries no write and no Tnew.
  // -------------------------------------------------------------------------
  logic                 entry_we;
  logic [4:0]           entry_a3;
  logic [TNEW_W-1:0]    entry_tnew;
  logic [PC_W-1:0]      bubble_pc;

  assign entry_we   = in_wegrf & in_valid & (in_a3 != 5'd0);
  assign entry_a3   = entry_we ? in_a3 : 5'd0;
  assign entry_tnew = in_valid ? tnew_dec(in_tnew) : '0;
  assign bubble_pc  = KEEP_PC_ON_BUBBLE ? in_pc : PC_RESET;

  // -------------------------------------------------------------------------
  // Next-state. The default is "keep", which is exactly the hold behaviour;
  // reset and flush_all are applied in the sequential block since they
  // override everything.
  // -------------------------------------------------------------------------
  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    pc_d      = pc_q;
    tnew_d    = tnew_q;
    wegrf_d   = wegrf_q;
    a3_d      = a3_q;

    if (!hold) begin
      // Entry slice: bubble on flush, otherwise the gated upstream values.
      if (flush) begin
        valid_d[0]   = 1'b0;
        payload_d[0] = '0;
        pc_d[0]      = bubble_pc;
        tnew_d[0]    = '0;
        wegrf_d[0]   = 1'b0;
        a3_d[0]      = 5'd0;
      end else begin
        valid_d[0]   = in_valid;
        payload_d[0] = in_payload;
        pc_d[0]      = in_pc;
        tnew_d[0]    = entry_tnew;
        wegrf_d[0]   = entry_we;
        a3_d[0]      = entry_a3;
      end

      // Later slices always advance, ageing Tnew by one cycle per slice.
      for (int k = 1; k < int'(DEPTH); k++) begin
        valid_d[k]   = valid_q[k-1];
        payload_d[k] = payload_q[k-1];
        pc_d[k]      = pc_q[k-1];
        tnew_d[k]    = tnew_dec(tnew_q[k-1]);
        wegrf_d[k]   = wegrf_q[k-1];
        a3_d[k]      = a3_q[k-1];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Slice registers. reset and flush_all produce the same all-bubble state,
  // including during a hold or a partially filled pipeline.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset || flush_all) begin
      valid_q   <= '0;
      payload_q <= '0;
      pc_q      <= {DEPTH{PC_RESET}};
      tnew_q    <= '0;
      wegrf_q   <= '0;
      a3_q      <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
      pc_q      <= pc_d;
      tnew_q    <= tnew_d;
      wegrf_q   <= wegrf_d;
      a3_q      <= a3_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs come straight from the last slice: no input-to-output path.
  // -------------------------------------------------------------------------
  assign out_valid   = valid_q[DEPTH-1];
  assign out_payload = payload_q[DEPTH-1];
  assign out_pc      = pc_q[DEPTH-1];
  assign out_tnew    = tnew_q[DEPTH-1];
  assign out_wegrf   = wegrf_q[DEPTH-1];
  assign out_a3      = a3_q[DEPTH-1];
  assign busy        = |valid_q;

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the five-stage MIPS core. It is the successor to the fixed-field D->E register.
- Carries an opaque control/data payload, PC, and hazard bookkeeping (Tnew, GRF write enable, write address A3) through DEPTH chained slices.
- Supports hold (stall), bubble insertion at entry, and full flush.
- Instantiated between every stage pair (D/E, E/M, M/W). DEPTH>1 is used for multi-cycle E-stage paths.

Parameters:
- PAYLOAD_W, 128, width of opaque payload (ALUop, DM_type, imm32, RD1/RD2, etc. packed by the instantiating stage)
- PC_W, 32, width of PC field
- TNEW_W, 2, width of Tnew field
- DEPTH, 1, number of chained register slices (1..4)
- KEEP_PC_ON_BUBBLE, 1, 1: a bubble inserted by flush takes in_pc; 0: bubble PC = PC_RESET
- PC_RESET, 0, PC value of every slice after reset or flush_all

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- hold  input  1  freeze all slices (this stage stalled)
- flush  input  1  load a bubble into slice 0 while later slices advance
- flush_all  input  1  clear every slice to bubble
- in_valid  input  1  upstream instruction is real
- in_payload  input  PAYLOAD_W  upstream payload
- in_pc  input  PC_W  upstream PC
- in_tnew  input  TNEW_W  upstream Tnew
- in_wegrf  input  1  upstream GRF write enable
- in_a3  input  5  upstream GRF write address
- out_valid  output  1  last slice holds a real instruction
- out_payload  output  PAYLOAD_W  last slice payload
- out_pc  output  PC_W  last slice PC
- out_tnew  output  TNEW_W  last slice Tnew
- out_wegrf  output  1  last slice write enable (already gated)
- out_a3  output  5  last slice write address
- busy  output  1  OR of valid over all slices

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Register reset state (all slices): valid=0, payload=0, pc=PC_RESET, tnew=0, wegrf=0, a3=0. Outputs therefore read the same values, and busy=0, from the first edge with reset high.
- All outputs are registered and driven directly from the last slice. There is no combinational path from inputs to outputs.
- Latency: in_* appears on out_* DEPTH edges after capture, provided hold is low on each of those edges.
- Priority on each edge: reset > flush_all > hold > flush > normal advance.
- flush_all: every slice becomes a bubble with pc=PC_RESET.
- hold: every slice keeps its contents, including tnew (no decrement). A simultaneous flush is ignored.
- flush (hold low):
  - Slice 0 gets a bubble: valid=0, payload=0, tnew=0, wegrf=0, a3=0.
  - Bubble pc = in_pc if KEEP_PC_ON_BUBBLE=1, else PC_RESET.
  - Slices 1..DEPTH-1 advance normally.
- Normal advance into slice 0:
  - valid=in_valid and payload=in_payload.
  - pc=in_pc.
  - tnew = in_tnew-1, saturating at 0.
  - wegrf = in_wegrf & in_valid & (in_a3!=0).
  - a3 = (wegrf term) ? in_a3 : 0.
- Normal advance into slice k>0: slice k takes slice k-1 with tnew decremented, saturating at 0. All other fields are copied unchanged.
- Invariant: wegrf=0 implies a3=0, and valid=0 implies wegrf=0 and tnew=0. Hazard units may therefore compare a3 without checking valid.
- Register 0 rule: writes to $0 never propagate, so in_a3=0 forces wegrf=0 regardless of in_wegrf.
- Reset during a held or partially filled pipeline clears every slice on that edge. No in-flight data survives.
- DEPTH outside 1..4: elaboration error via generate-time check.

Test Plan:
- Reset, DEPTH=1: hold reset high 2 edges with in_valid=1 -> out_valid=0, out_pc=PC_RESET, out_tnew=0, out_a3=0, busy=0.
- Advance and Tnew saturation, DEPTH=1: in_tnew=2, in_pc=0x3004, in_a3=8, in_wegrf=1 -> next edge out_tnew=1, out_a3=8, out_wegrf=1, out_pc=0x3004. Repeat with in_tnew=0 -> out_tnew=0.
- $0 and invalid gating: in_a3=0, in_wegrf=1 -> out_wegrf=0, out_a3=0. in_valid=0, in_a3=5 -> out_wegrf=0, out_a3=0, out_tnew=0.
- Hold vs flush, DEPTH=1: load pc=0x3010, tnew=2 (out_tnew=1). Assert hold and flush together for 3 edges -> outputs unchanged, out_tnew stays 1. Then flush alone with in_pc=0x3014 -> out_valid=0, out_pc=0x3014. Rerun with KEEP_PC_ON_BUBBLE=0 -> out_pc=PC_RESET.
- Depth chaining, DEPTH=3:
  - Inject in_tnew=3 on edge 0 -> out_valid=1 on edge 2 with out_tnew=0 (3->2->1->0).
  - flush on edge 1 -> the first instruction still emerges, followed by one bubble.
  - A hold pulse inserted mid-flight adds exactly one cycle of latency.
- Flush_all and reset mid-operation, DEPTH=3: fill 3 valid instructions (busy=1).
  - Assert flush_all with hold=1 -> all slices become bubbles next edge, busy=0, out_pc=PC_RESET.
  - Repeat with reset instead of flush_all -> same result.
